// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with bounded hold time.
// Drives a registered one-hot grant and the matching DMux8Way select.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    state_t            state;
    logic [2:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic [2:0] win_ptr;
    logic [2:0] sel_next;
    logic [2:0] win_rot;
    logic       others;
    logic       hold_last;

    // First set bit of r, scanning start, start+1, ... with wrap from 7 to 0.
    function automatic logic [2:0] find_winner(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        find_winner = start;
        found       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && r[idx]) begin
                find_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

    always_comb begin
        win_ptr   = find_winner(req, ptr);
        sel_next  = sel + 3'd1;
        win_rot   = find_winner(req, sel_next);
        others    = |(req & ~(8'd1 << sel));
        hold_last = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 8'h00;
            sel      <= 3'd0;
            valid    <= 1'b0;
            ptr      <= 3'd0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        grant    <= 8'd1 << win_ptr;
                        sel      <= win_ptr;
                        valid    <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        grant <= 8'h00;
                        valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[sel]) begin
                        ptr <= sel_next;
                        if (|req) begin
                            grant    <= 8'd1 << win_rot;
                            sel      <= win_rot;
                            hold_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            grant <= 8'h00;
                            valid <= 1'b0;
                        end
                    end else if (hold_last) begin
                        // Holder is still requesting; it yields only if someone else waits.
                        hold_cnt <= '0;
                        if (others) begin
                            ptr   <= sel_next;
                            grant <= 8'd1 << win_rot;
                            sel   <= win_rot;
                        end
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 8'h00;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Eight-requester round-robin arbiter that schedules a shared single-bit resource.
- Produces a registered one-hot grant plus the 3-bit select that drives DMux8Way, which steers the shared strobe to the winning slot.
- Sits between up to eight requesters (for example RAM8 register load sources) and the DMux8Way/RAM8 datapath.
- Guarantees fairness by rotating priority and by bounding grant hold time.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one grant may be held while others wait. 0 disables forced rotation.
- HOLD_W, 5: width of the internal hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit i = requester i wants the resource.
- grant  output  8  registered one-hot grant; all-zero when idle.
- sel  output  3  registered index of the granted requester, wired to DMux8Way sel.
- valid  output  1  registered; high whenever grant is non-zero.

Behaviour:
- Reset, asynchronous, applied immediately without a clock edge:
  - state=IDLE, grant=8'h00, sel=3'b000, valid=0.
  - priority pointer ptr=0, hold_cnt=0.
  - Reset mid-grant drops grant and valid at once. After reset release, arbitration restarts from ptr=0.
- States: IDLE, GRANT. All outputs are registered. There is no combinational path from req to grant.
- Winner search: first set bit of req scanning ptr, ptr+1 … ptr+7, modulo 8 (wrap 7→0).
- IDLE:
  - req==0: stay IDLE, outputs unchanged. sel keeps its last value, grant=0, valid=0.
  - req!=0: at the next edge go to GRANT; grant=onehot(winner), sel=winner, valid=1, hold_cnt=0.
  - Latency from req sampled to grant visible: 1 cycle.
- GRANT, evaluated each edge on sampled req:
  - Release, req[sel]==0:
    - ptr <= sel+1 (mod 8).
    - If other requests are pending: grant the next winner, searched from sel+1, at the same edge. No idle bubble; hold_cnt=0.
    - Otherwise: go to IDLE with grant=0 and valid=0; sel holds.
  - Forced rotation: MAX_HOLD!=0, req[sel]==1, hold_cnt==MAX_HOLD-1.
    - If any other req bit is set: ptr <= sel+1 and grant the next winner from sel+1. The current holder loses even though it is still requesting.
    - If no other req bit is set: keep the grant and set hold_cnt=0. Grant never drops.
  - Otherwise: hold the grant and increment hold_cnt. hold_cnt saturates at 2^HOLD_W-1 when MAX_HOLD==0.
  - A grant therefore lasts at most MAX_HOLD cycles while contention exists.
- Non-granted req bits may toggle freely; they only matter at arbitration points (IDLE, release, forced rotation).
- Invariants checked every cycle:
  - grant is one-hot or zero.
  - valid==|grant.
  - grant==onehot(sel) whenever valid.
- Simultaneous release and forced rotation: treated as release; the same result follows.

Test Plan:
1. Reset, then req=8'h01 → next edge grant=8'h01, sel=0, valid=1. Drop req → next edge grant=0, valid=0, sel stays 0.
2. After reset, req=8'hA4 → grant sel=2. Clear req[2] → next edge sel=5 with no valid gap. Clear req[5] → sel=7. Clear req[7] → IDLE, grant=0.
3. MAX_HOLD=4, req=8'h03 held constant → grant alternates 8'h01 for 4 cycles, 8'h02 for 4 cycles, repeating. valid stays 1 throughout.
4. MAX_HOLD=4, req=8'h08 held 10 cycles → grant=8'h08 and valid=1 on every cycle, no drop or glitch.
5. Wrap-around: grant at sel=7 with req=8'h81; clear bit 7 → next edge sel=0, grant=8'h01.
6. Assert reset asynchronously mid-cycle during grant sel=5 → grant=0, valid=0, sel=0 before the next clock edge. Release reset with req=8'h21 → grant sel=0 (ptr reset to 0).
